// File: rtl/binding_unit.sv
// HDC binding stage: pass / permute / XOR-bind / n-gram accumulation behind a
// valid/ready handshake with a single registered output slot.
module binding_unit #(
   parameter int HV_LENGTH  = 1024,
   parameter int SHIFT_SIZE = 6,
   parameter int NGRAM_MAX  = 8,
   parameter int CNT_W      = $clog2(NGRAM_MAX + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [HV_LENGTH-1:0]  im_hv_in,
   input  logic [HV_LENGTH-1:0]  key_hv_in,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            binding_mode,
   input  logic [SHIFT_SIZE-1:0] shift_amount,
   input  logic [CNT_W-1:0]      ngram_len,
   input  logic                  flush,
   output logic [HV_LENGTH-1:0]  binding_hv_out,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  group_busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   state_t                state, state_n;
   logic [HV_LENGTH-1:0]  acc, acc_n;
   logic [CNT_W-1:0]      count, count_n;
   logic [CNT_W-1:0]      n_lat, n_lat_n;
   logic [SHIFT_SIZE-1:0] s_lat, s_lat_n;
   logic [CNT_W-1:0]      n_eff;
   logic [HV_LENGTH-1:0]  result;
   logic [HV_LENGTH-1:0]  acc_next;
   logic                  produce;
   logic                  accept;

   // Circular left rotate: bit i lands at (i + s) mod HV_LENGTH.
   function automatic logic [HV_LENGTH-1:0] rot(input logic [HV_LENGTH-1:0] x,
                                                input logic [SHIFT_SIZE-1:0] s);
      logic [2*HV_LENGTH-1:0] dbl;
      int unsigned            amt;
      amt = 32'(s) % 32'(HV_LENGTH);
      dbl = {x, x} << amt;
      return dbl[2*HV_LENGTH-1:HV_LENGTH];
   endfunction

   assign in_ready   = !out_valid || out_ready;
   assign accept     = in_valid && in_ready;
   assign group_busy = (state == ACCUM);
   assign acc_next   = rot(acc, s_lat) ^ im_hv_in;

   always_comb begin
      n_eff = ngram_len;
      if (ngram_len == '0)
         n_eff = CNT_W'(1);
      else if (ngram_len > CNT_W'(NGRAM_MAX))
         n_eff = CNT_W'(NGRAM_MAX);
   end

   always_comb begin
      state_n = state;
      acc_n   = acc;
      count_n = count;
      n_lat_n = n_lat;
      s_lat_n = s_lat;
      produce = 1'b0;
      result  = '0;

      // Flush aborts the group even while stalled; it never touches the output slot.
      if (flush && state == ACCUM) begin
         state_n = IDLE;
         acc_n   = '0;
         count_n = '0;
      end

      if (accept) begin
         if (state == ACCUM && !flush) begin
            if (count + CNT_W'(1) == n_lat) begin
               produce = 1'b1;
               result  = acc_next;
               acc_n   = '0;
               count_n = '0;
               state_n = IDLE;
            end else begin
               acc_n   = acc_next;
               count_n = count + CNT_W'(1);
            end
         end else begin
            unique case (binding_mode)
               2'd0: begin
                  produce = 1'b1;
                  result  = im_hv_in;
               end
               2'd1: begin
                  produce = 1'b1;
                  result  = rot(im_hv_in, shift_amount);
               end
               2'd2: begin
                  produce = 1'b1;
                  result  = im_hv_in ^ key_hv_in;
               end
               2'd3: begin
                  if (n_eff == CNT_W'(1)) begin
                     produce = 1'b1;
                     result  = im_hv_in;
                  end else begin
                     acc_n   = im_hv_in;
                     count_n = CNT_W'(1);
                     n_lat_n = n_eff;
                     s_lat_n = shift_amount;
                     state_n = ACCUM;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state          <= IDLE;
         acc            <= '0;
         count          <= '0;
         n_lat          <= '0;
         s_lat          <= '0;
         binding_hv_out <= '0;
         out_valid      <= 1'b0;
      end else begin
         state <= state_n;
         acc   <= acc_n;
         count <= count_n;
         n_lat <= n_lat_n;
         s_lat <= s_lat_n;
         if (produce) begin
            binding_hv_out <= result;
            out_valid      <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_binding_unit.sv
// Directed plus randomized checks of binding_unit against a queue-based n-gram model.
module tb_binding_unit;

   localparam int HV = 16;
   localparam int SS = 4;
   localparam int NM = 4;
   localparam int CW = $clog2(NM + 1);

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic [HV-1:0] im_hv_in = '0;
   logic [HV-1:0] key_hv_in = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [1:0]    binding_mode = '0;
   logic [SS-1:0] shift_amount = '0;
   logic [CW-1:0] ngram_len = '0;
   logic          flush = 1'b0;
   logic [HV-1:0] binding_hv_out;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic          group_busy;

   binding_unit #(.HV_LENGTH(HV), .SHIFT_SIZE(SS), .NGRAM_MAX(NM)) dut (
      .clk_i(clk), .rst_i(rst_i), .im_hv_in(im_hv_in), .key_hv_in(key_hv_in),
      .in_valid(in_valid), .in_ready(in_ready), .binding_mode(binding_mode),
      .shift_amount(shift_amount), .ngram_len(ngram_len), .flush(flush),
      .binding_hv_out(binding_hv_out), .out_valid(out_valid),
      .out_ready(out_ready), .group_busy(group_busy)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   // reference model state
   bit [HV-1:0] m_out = '0;
   bit          m_vld = 1'b0;
   bit          m_busy = 1'b0;
   bit [HV-1:0] grp[$];
   int          g_n = 0;
   int          g_s = 0;

   function automatic bit [HV-1:0] mrot(bit [HV-1:0] x, int s);
      bit [HV-1:0] r;
      for (int i = 0; i < HV; i++) r[(i + s) % HV] = x[i];
      return r;
   endfunction

   // n-gram = XOR of element i rotated by s*(N-1-i)
   function automatic bit [HV-1:0] mgram();
      bit [HV-1:0] r = '0;
      for (int i = 0; i < grp.size(); i++)
         r ^= mrot(grp[i], g_s * (grp.size() - 1 - i));
      return r;
   endfunction

   task automatic chk(string tag, logic [HV-1:0] obs, logic [HV-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
   endtask

   task automatic model_update();
      bit          rdy, prod;
      bit [HV-1:0] res;
      int          n;
      prod = 0;
      res  = '0;
      if (rst_i) begin
         m_out = '0; m_vld = 0; m_busy = 0; grp.delete();
         return;
      end
      rdy = !m_vld || out_ready;
      if (flush && m_busy) begin
         m_busy = 0; grp.delete();
      end
      if (in_valid && rdy) begin
         if (m_busy) begin
            grp.push_back(im_hv_in);
            if (grp.size() == g_n) begin
               prod = 1; res = mgram(); m_busy = 0; grp.delete();
            end
         end else begin
            case (binding_mode)
               2'd0: begin prod = 1; res = im_hv_in; end
               2'd1: begin prod = 1; res = mrot(im_hv_in, int'(shift_amount)); end
               2'd2: begin prod = 1; res = im_hv_in ^ key_hv_in; end
               default: begin
                  n = (ngram_len == 0) ? 1 : (int'(ngram_len) > NM ? NM : int'(ngram_len));
                  if (n == 1) begin
                     prod = 1; res = im_hv_in;
                  end else begin
                     m_busy = 1; grp.delete(); grp.push_back(im_hv_in);
                     g_n = n; g_s = int'(shift_amount);
                  end
               end
            endcase
         end
      end
      if (prod) begin
         m_out = res; m_vld = 1;
      end else if (out_ready) begin
         m_vld = 0;
      end
   endtask

   // one clock: check in_ready before the edge, model the edge, check outputs after
   task automatic tick();
      #1;
      chk("in_ready", in_ready, (!m_vld || out_ready));
      @(posedge clk);
      model_update();
      #1;
      chk("out_valid", out_valid, m_vld);
      chk("group_busy", group_busy, m_busy);
      if (m_vld || rst_i) chk("hv_out", binding_hv_out, m_out);
   endtask

   task automatic drive(bit v, bit [1:0] m, bit [HV-1:0] im, bit [SS-1:0] s, bit [CW-1:0] n);
      in_valid = v; binding_mode = m; im_hv_in = im; shift_amount = s; ngram_len = n;
   endtask

   initial begin
      // reset
      rst_i = 1'b1;
      tick(); tick();
      rst_i = 1'b0;
      drive(0, 0, '0, 0, 0);
      tick();
      chk("rst_out", binding_hv_out, 16'h0000);
      chk("rst_vld", out_valid, 1'b0);
      chk("rst_busy", group_busy, 1'b0);
      chk("rst_rdy", in_ready, 1'b1);

      // permute
      drive(1, 1, 16'h0001, 3, 1); tick(); chk("rot3", binding_hv_out, 16'h0008);
      drive(1, 1, 16'h8001, 1, 1); tick(); chk("rot_wrap", binding_hv_out, 16'h0003);
      drive(1, 1, 16'hABCD, 0, 1); tick(); chk("rot0", binding_hv_out, 16'hABCD);

      // XOR bind
      key_hv_in = 16'hFF00;
      drive(1, 2, 16'hF0F0, 0, 1); tick(); chk("xor", binding_hv_out, 16'h0FF0);

      // n-gram N=3, s=1
      drive(1, 3, 16'h0001, 1, 3); tick();
      chk("ng_e1_vld", out_valid, 1'b0); chk("ng_e1_busy", group_busy, 1'b1);
      drive(1, 0, 16'h0001, 3, 1); tick();   // mode/shift/len ignored mid-group
      chk("ng_e2_vld", out_valid, 1'b0); chk("ng_e2_busy", group_busy, 1'b1);
      tick();
      chk("ng_res", binding_hv_out, 16'h0007); chk("ng_vld", out_valid, 1'b1);
      chk("ng_busy", group_busy, 1'b0);
      drive(1, 3, 16'h1234, 2, 0); tick(); chk("ng_n0", binding_hv_out, 16'h1234);

      // backpressure
      out_ready = 1'b0;
      drive(1, 0, 16'h5555, 0, 1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("bp_hold", binding_hv_out, 16'h1234);
         chk("bp_rdy", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_load", binding_hv_out, 16'h5555); chk("bp_vld", out_valid, 1'b1);

      // flush mid-group, then a clean group
      drive(1, 3, 16'h0001, 1, 3); tick(); tick();
      in_valid = 1'b0; flush = 1'b1; tick(); flush = 1'b0;
      chk("fl_busy", group_busy, 1'b0); chk("fl_vld", out_valid, 1'b0);
      drive(1, 3, 16'h0001, 1, 3); tick(); tick(); tick();
      chk("fl_next", binding_hv_out, 16'h0007);

      // reset mid-group, then a clean group
      drive(1, 3, 16'h0001, 1, 3); tick(); tick();
      rst_i = 1'b1; tick(); rst_i = 1'b0;
      chk("rm_out", binding_hv_out, 16'h0000); chk("rm_vld", out_valid, 1'b0);
      chk("rm_busy", group_busy, 1'b0);
      tick(); tick(); tick();
      chk("rm_next", binding_hv_out, 16'h0007);

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         rst_i        = ($urandom_range(0, 79) == 0);
         in_valid     = ($urandom_range(0, 3) != 0);
         binding_mode = 2'($urandom_range(0, 3));
         im_hv_in     = 16'($urandom);
         key_hv_in    = 16'($urandom);
         shift_amount = SS'($urandom);
         ngram_len    = CW'($urandom);
         flush        = ($urandom_range(0, 11) == 0);
         out_ready    = ($urandom_range(0, 2) != 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/binding_unit.md
Name: binding_unit

Overview:
Parametrised successor of the single-cycle permutation binder. It supports four binding modes: pass, permute, XOR-bind with a key HV, and n-gram accumulation (rotate-and-XOR over a sequence of HVs). It uses a valid/ready handshake with backpressure and a registered output. It sits between the item memory and the bundling/similarity stages of the HDC encoder.

Parameters:
HV_LENGTH, 1024, hypervector width in bits
SHIFT_SIZE, 6, width of shift_amount; rotation is by shift_amount mod HV_LENGTH
NGRAM_MAX, 8, maximum n-gram length; the group counter is $clog2(NGRAM_MAX+1) bits (CNT_W)

Ports:
clk_i  in  1  clock; all logic is rising-edge
rst_i  in  1  reset, synchronous, active-high
im_hv_in  in  HV_LENGTH  input hypervector
key_hv_in  in  HV_LENGTH  key hypervector (XOR mode)
in_valid  in  1  input HV valid
in_ready  out  1  unit can accept an input this cycle
binding_mode  in  2  0 pass, 1 permute, 2 XOR-bind, 3 n-gram
shift_amount  in  SHIFT_SIZE  rotation amount
ngram_len  in  CNT_W  n-gram length; 0 is treated as 1; values above NGRAM_MAX are clamped to NGRAM_MAX
flush  in  1  abort the open n-gram group
binding_hv_out  out  HV_LENGTH  result hypervector
out_valid  out  1  binding_hv_out is valid
out_ready  in  1  downstream accepts the result
group_busy  out  1  an n-gram group is open

Behaviour:
- Reset (rst_i=1 at a clock edge, including mid-group or mid-stall): binding_hv_out=0, out_valid=0, accumulator=0, count=0, group_busy=0. Any pending result is dropped.
- rot(x,s): circular left rotate, so bit i moves to bit (i+s) mod HV_LENGTH.
- Accept: a transfer occurs when in_valid && in_ready.
- in_ready = !out_valid || out_ready. This holds in every mode, including mid-group. It is not forced low by rst_i; inputs are ignored while rst_i=1.
- Output register: loads on an output-producing accept and sets out_valid.
  - It holds its value while out_valid && !out_ready.
  - out_valid clears on out_ready when nothing new is produced that cycle.
  - Simultaneous drain and produce: load the new value and keep out_valid=1.
  - Latency is 1 cycle from an output-producing accept to out_valid.
- Mode 0: result = im_hv_in.
- Mode 1: result = rot(im_hv_in, shift_amount).
- Mode 2: result = im_hv_in XOR key_hv_in.
- Modes 0–2 ignore the accumulator and do not touch it, unless they arrive while a group is open (see the group rules below).
- Mode 3 is an n-gram FSM with two states, IDLE and ACCUM.
  - IDLE, accept with N = effective ngram_len:
    - N==1: result = im_hv_in, stay IDLE.
    - Otherwise: acc = im_hv_in, count=1, latch N and shift_amount as the group config, go to ACCUM, group_busy=1.
  - ACCUM, accept: next = rot(acc, s_latched) XOR im_hv_in.
    - If count+1 == N_latched: result = next, acc=0, count=0, go to IDLE.
    - Otherwise: acc=next, count++. No output is produced for this element.
  - While ACCUM, binding_mode, shift_amount and ngram_len are ignored. Every accept is treated as the next n-gram element until the group closes or is flushed.
- flush:
  - In ACCUM: clear acc/count, go to IDLE, produce no output.
  - Flush together with an accept: flush first, then the input is processed as a fresh IDLE accept under the current mode.
  - Flush in IDLE: no effect.
  - The output register and out_valid are never affected by flush.
- Stall: when in_ready=0, the FSM, acc and count hold.

Test Plan (HV_LENGTH=16, SHIFT_SIZE=4, NGRAM_MAX=4):
- Reset: assert rst_i for 2 cycles, then release -> binding_hv_out=0, out_valid=0, group_busy=0, in_ready=1.
- Mode 1, im=16'h0001, s=3, then im=16'h8001, s=1 -> out_valid next cycle with 16'h0008, then 16'h0003 (wrap). With s=0 -> out equals input.
- Mode 2, im=16'hF0F0, key=16'hFF00 -> 16'h0FF0 one cycle after accept.
- Mode 3, N=3, s=1, three accepts of 16'h0001 -> no out_valid after elements 1–2 and group_busy=1; result 16'h0007 one cycle after the third accept; group_busy=0. N=0 with im=16'h1234 -> 16'h1234.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1 -> binding_hv_out stable and in_ready=0, acc/count unchanged. Raise out_ready with a simultaneous accept -> new result loaded, out_valid stays 1.
- Mode 3, N=3: flush after 2 elements -> group_busy=0, no output. A following N=3 group of 16'h0001 x3 -> 16'h0007. Repeat with rst_i instead of flush mid-group -> all outputs 0, next group also gives 16'h0007.
